// File: rtl/rf_pkg.sv
// Shared constants and types for the parametrised integer register file
// and its busy scoreboard.
package rf_pkg;

   localparam int XLEN_DEFAULT  = 32;
   localparam int NREGS_DEFAULT = 32;
   localparam int ZERO_REG      = 0;

   typedef logic [$clog2(NREGS_DEFAULT)-1:0] reg_idx_t;
   typedef logic [XLEN_DEFAULT-1:0]          xword_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write flags for the ID hazard unit: set on issue,
// cleared on writeback, with a running count of busy registers.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter  int NREGS  = NREGS_DEFAULT,
   parameter  bit BYPASS = 1'b1,
   localparam int AW     = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] rs1,
   input  logic [AW-1:0] rs2,
   output logic          rs1_busy,
   output logic          rs2_busy,
   input  logic          regwrite,
   input  logic [AW-1:0] rd,
   input  logic          alloc_en,
   input  logic [AW-1:0] alloc_rd,
   output logic [AW:0]   busy_cnt
);

   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_next;
   logic             set_new;
   logic             clr_old;

   // NOTE: blocking assignments in always_comb; the later alloc write
   // overriding the earlier writeback clear is what gives set-over-clear.
   always_comb begin
      busy_next = busy;
      if (regwrite) busy_next[rd] = 1'b0;
      if (alloc_en) busy_next[alloc_rd] = 1'b1;
      busy_next[ZERO_REG] = 1'b0;
   end

   // Count deltas only where a bit actually flips, so the count tracks popcount.
   assign set_new = alloc_en && (alloc_rd != AW'(ZERO_REG)) && !busy[alloc_rd];
   assign clr_old = regwrite && (rd != AW'(ZERO_REG)) && busy[rd]
                    && !(alloc_en && (alloc_rd == rd));

   // NOTE: non-blocking assignments for all sequential state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         busy     <= busy_next;
         busy_cnt <= busy_cnt + (AW+1)'(set_new) - (AW+1)'(clr_old);
      end
   end

   generate
      if (BYPASS) begin : g_bypass
         assign rs1_busy = busy[rs1] & ~(regwrite && (rd == rs1));
         assign rs2_busy = busy[rs2] & ~(regwrite && (rd == rs2));
      end else begin : g_no_bypass
         assign rs1_busy = busy[rs1];
         assign rs2_busy = busy[rs2];
      end
   endgenerate

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file: two combinational read ports, one synchronous write
// port, optional write-to-read bypass and an integrated busy scoreboard.
module reg_file_sb
   import rf_pkg::*;
#(
   parameter  int XLEN   = XLEN_DEFAULT,
   parameter  int NREGS  = NREGS_DEFAULT,
   parameter  bit BYPASS = 1'b1,
   localparam int AW     = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   output logic            rs1_busy,
   output logic            rs2_busy,
   input  logic            regwrite,
   input  logic [AW-1:0]   rd,
   input  logic [XLEN-1:0] wd,
   input  logic            alloc_en,
   input  logic [AW-1:0]   alloc_rd,
   output logic [AW:0]     busy_cnt
);

   logic [XLEN-1:0] regs [NREGS];
   logic            wr_en;

   assign wr_en = regwrite && (rd != AW'(ZERO_REG));

   // NOTE: the array lives in flops with an async clear because reset must
   // zero every register; entry 0 is never written and so stays zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wr_en) begin
         regs[rd] <= wd;
      end
   end

   always_comb begin
      rd1 = regs[rs1];
      rd2 = regs[rs2];
      if (BYPASS && wr_en && (rd == rs1)) rd1 = wd;
      if (BYPASS && wr_en && (rd == rs2)) rd2 = wd;
   end

   rf_scoreboard #(
      .NREGS  (NREGS),
      .BYPASS (BYPASS)
   ) u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .rs1      (rs1),
      .rs2      (rs2),
      .rs1_busy (rs1_busy),
      .rs2_busy (rs2_busy),
      .regwrite (regwrite),
      .rd       (rd),
      .alloc_en (alloc_en),
      .alloc_rd (alloc_rd),
      .busy_cnt (busy_cnt)
   );

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a default 32x32 bypassing instance and a 16x64
// non-bypassing instance, each compared every cycle against an array model.
module tb_reg_file_sb;
   import rf_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   reg_idx_t   a_rs1, a_rs2, a_rd, a_alloc_rd;
   xword_t     a_rd1, a_rd2, a_wd;
   logic       a_rs1_busy, a_rs2_busy, a_regwrite, a_alloc_en;
   logic [5:0] a_busy_cnt;

   logic [3:0]  b_rs1, b_rs2, b_rd, b_alloc_rd;
   logic [63:0] b_rd1, b_rd2, b_wd;
   logic        b_rs1_busy, b_rs2_busy, b_regwrite, b_alloc_en;
   logic [4:0]  b_busy_cnt;

   reg_file_sb dut_a (
      .clk (clk), .rst_n (rst_n), .rs1 (a_rs1), .rs2 (a_rs2),
      .rd1 (a_rd1), .rd2 (a_rd2), .rs1_busy (a_rs1_busy), .rs2_busy (a_rs2_busy),
      .regwrite (a_regwrite), .rd (a_rd), .wd (a_wd),
      .alloc_en (a_alloc_en), .alloc_rd (a_alloc_rd), .busy_cnt (a_busy_cnt)
   );

   reg_file_sb #(.XLEN (64), .NREGS (16), .BYPASS (1'b0)) dut_b (
      .clk (clk), .rst_n (rst_n), .rs1 (b_rs1), .rs2 (b_rs2),
      .rd1 (b_rd1), .rd2 (b_rd2), .rs1_busy (b_rs1_busy), .rs2_busy (b_rs2_busy),
      .regwrite (b_regwrite), .rd (b_rd), .wd (b_wd),
      .alloc_en (b_alloc_en), .alloc_rd (b_alloc_rd), .busy_cnt (b_busy_cnt)
   );

   // Reference state: architectural register contents and pending flags.
   xword_t      ma_regs [32];
   bit          ma_busy [32];
   logic [63:0] mb_regs [16];
   bit          mb_busy [16];

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic reset_models();
      foreach (ma_regs[i]) begin ma_regs[i] = '0; ma_busy[i] = 1'b0; end
      foreach (mb_regs[i]) begin mb_regs[i] = '0; mb_busy[i] = 1'b0; end
   endtask

   function automatic int pop_a();
      int n = 0;
      foreach (ma_busy[i]) n += int'(ma_busy[i]);
      return n;
   endfunction

   function automatic int pop_b();
      int n = 0;
      foreach (mb_busy[i]) n += int'(mb_busy[i]);
      return n;
   endfunction

   // Bypassing instance: a same-cycle writeback is visible on the read side.
   function automatic xword_t exp_a_data(reg_idx_t rs);
      if (rs == 0) return '0;
      if (a_regwrite && a_rd == rs) return a_wd;
      return ma_regs[rs];
   endfunction

   function automatic bit exp_a_busy(reg_idx_t rs);
      if (rs == 0) return 1'b0;
      if (a_regwrite && a_rd == rs) return 1'b0;
      return ma_busy[rs];
   endfunction

   task automatic drive_a(input logic rw, input reg_idx_t wr_idx, input xword_t wdata,
                          input logic ae, input reg_idx_t a_idx,
                          input reg_idx_t r1, input reg_idx_t r2);
      a_regwrite = rw; a_rd = wr_idx; a_wd = wdata;
      a_alloc_en = ae; a_alloc_rd = a_idx; a_rs1 = r1; a_rs2 = r2;
   endtask

   task automatic drive_b(input logic rw, input logic [3:0] wr_idx, input logic [63:0] wdata,
                          input logic ae, input logic [3:0] a_idx,
                          input logic [3:0] r1, input logic [3:0] r2);
      b_regwrite = rw; b_rd = wr_idx; b_wd = wdata;
      b_alloc_en = ae; b_alloc_rd = a_idx; b_rs1 = r1; b_rs2 = r2;
   endtask

   // Compare all outputs of both instances mid-cycle.
   task automatic settle();
      @(negedge clk);
      check("a_rd1",      64'(a_rd1),      64'(exp_a_data(a_rs1)));
      check("a_rd2",      64'(a_rd2),      64'(exp_a_data(a_rs2)));
      check("a_rs1_busy", 64'(a_rs1_busy), 64'(exp_a_busy(a_rs1)));
      check("a_rs2_busy", 64'(a_rs2_busy), 64'(exp_a_busy(a_rs2)));
      check("a_busy_cnt", 64'(a_busy_cnt), 64'(pop_a()));
      check("b_rd1",      b_rd1,           (b_rs1 == 0) ? 64'd0 : mb_regs[b_rs1]);
      check("b_rd2",      b_rd2,           (b_rs2 == 0) ? 64'd0 : mb_regs[b_rs2]);
      check("b_rs1_busy", 64'(b_rs1_busy), 64'(mb_busy[b_rs1]));
      check("b_rs2_busy", 64'(b_rs2_busy), 64'(mb_busy[b_rs2]));
      check("b_busy_cnt", 64'(b_busy_cnt), 64'(pop_b()));
   endtask

   // Apply the clock edge to the model: write and clear first, then set.
   task automatic commit();
      @(posedge clk);
      if (a_regwrite && a_rd != 0) begin ma_regs[a_rd] = a_wd; ma_busy[a_rd] = 1'b0; end
      if (a_alloc_en && a_alloc_rd != 0) ma_busy[a_alloc_rd] = 1'b1;
      if (b_regwrite && b_rd != 0) begin mb_regs[b_rd] = b_wd; mb_busy[b_rd] = 1'b0; end
      if (b_alloc_en && b_alloc_rd != 0) mb_busy[b_alloc_rd] = 1'b1;
      #1;
   endtask

   task automatic random_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         drive_a(1'($urandom_range(0, 1)), reg_idx_t'($urandom_range(0, 7)), $urandom(),
                 1'($urandom_range(0, 1)), reg_idx_t'($urandom_range(0, 7)),
                 reg_idx_t'($urandom_range(0, 7)), reg_idx_t'($urandom_range(0, 7)));
         drive_b(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), {$urandom(), $urandom()},
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         settle();
         commit();
      end
   endtask

   initial begin
      rst_n = 1'b1;
      drive_a(0, 0, '0, 0, 0, 3, 6);
      drive_b(0, 0, '0, 0, 0, 3, 6);
      reset_models();
      #2 rst_n = 1'b0;
      #1;
      check("rst_a_rd1", 64'(a_rd1), 64'd0);
      check("rst_a_cnt", 64'(a_busy_cnt), 64'd0);
      check("rst_b_rd2", b_rd2, 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      settle();
      commit();

      // Write x6: bypassing instance forwards, non-bypassing shows old value.
      drive_a(1, 6, 32'hA456_2D47, 0, 0, 6, 0);
      drive_b(1, 6, 64'hA456_2D47, 0, 0, 6, 0);
      settle();
      check("a_x6_same_cycle", 64'(a_rd1), 64'h0000_0000_A456_2D47);
      check("b_x6_same_cycle", b_rd1, 64'd0);
      commit();
      drive_a(0, 0, '0, 0, 0, 6, 6);
      drive_b(0, 0, '0, 0, 0, 6, 0);
      settle();
      check("a_x6_next", 64'(a_rd1), 64'h0000_0000_A456_2D47);
      check("b_x6_next", b_rd1, 64'h0000_0000_A456_2D47);
      commit();

      // Writes and allocs aimed at x0 are ignored.
      drive_a(1, 0, 32'hDEAD_BEEF, 1, 0, 0, 0);
      drive_b(0, 0, '0, 0, 0, 0, 0);
      settle();
      check("a_x0_read", 64'(a_rd1), 64'd0);
      commit();
      drive_a(0, 0, '0, 0, 0, 0, 0);
      settle();
      check("a_x0_cnt", 64'(a_busy_cnt), 64'd0);
      check("a_x0_busy", 64'(a_rs1_busy), 64'd0);
      commit();

      // Alloc x7, then writeback clears busy combinationally.
      drive_a(0, 0, '0, 1, 7, 0, 7);
      settle();
      check("a_x7_alloc_same", 64'(a_rs2_busy), 64'd0);
      commit();
      drive_a(0, 0, '0, 0, 0, 0, 7);
      settle();
      check("a_x7_busy", 64'(a_rs2_busy), 64'd1);
      check("a_x7_cnt1", 64'(a_busy_cnt), 64'd1);
      commit();
      drive_a(1, 7, 32'hCAFE_BABE, 0, 0, 0, 7);
      settle();
      check("a_x7_wb_busy", 64'(a_rs2_busy), 64'd0);
      check("a_x7_wb_data", 64'(a_rd2), 64'h0000_0000_CAFE_BABE);
      commit();
      drive_a(0, 0, '0, 0, 0, 0, 7);
      settle();
      check("a_x7_cnt0", 64'(a_busy_cnt), 64'd0);
      commit();

      // x5 busy; simultaneous re-alloc and writeback keeps it busy.
      drive_a(0, 0, '0, 1, 5, 5, 5);
      settle();
      commit();
      drive_a(1, 5, 32'h1234_5678, 1, 5, 5, 0);
      settle();
      commit();
      drive_a(0, 0, '0, 0, 0, 5, 0);
      settle();
      check("a_x5_data", 64'(a_rd1), 64'h0000_0000_1234_5678);
      check("a_x5_busy", 64'(a_rs1_busy), 64'd1);
      check("a_x5_cnt", 64'(a_busy_cnt), 64'd1);
      commit();

      // 16x64 instance: write x15, alloc x1 and x15, writeback x1.
      drive_b(1, 15, 64'hFFFF_0000_1234_5678, 1, 1, 15, 1);
      settle();
      check("b_seq_cnt0", 64'(b_busy_cnt), 64'd0);
      commit();
      drive_b(0, 0, '0, 1, 15, 15, 1);
      settle();
      check("b_x1_busy", 64'(b_rs2_busy), 64'd1);
      commit();
      drive_b(1, 1, 64'h0123_4567_89AB_CDEF, 0, 0, 15, 1);
      settle();
      check("b_seq_cnt2", 64'(b_busy_cnt), 64'd2);
      check("b_x1_busy_reg", 64'(b_rs2_busy), 64'd1);
      commit();
      drive_b(0, 0, '0, 0, 0, 15, 1);
      settle();
      check("b_seq_cnt1", 64'(b_busy_cnt), 64'd1);
      check("b_x15_data", b_rd1, 64'hFFFF_0000_1234_5678);
      check("b_x1_data", b_rd2, 64'h0123_4567_89AB_CDEF);
      check("b_x15_busy", 64'(b_rs1_busy), 64'd1);
      check("b_x1_clear", 64'(b_rs2_busy), 64'd0);
      commit();

      random_cycles(400);

      // Asynchronous reset mid-cycle with pending allocations outstanding.
      drive_a(1, 3, 32'h5A5A_5A5A, 1, 4, 3, 4);
      drive_b(1, 9, 64'h5A5A_5A5A_0F0F_0F0F, 1, 10, 9, 10);
      settle();
      commit();
      drive_a(0, 0, '0, 0, 0, 3, 6);
      drive_b(0, 0, '0, 0, 0, 9, 15);
      #2 rst_n = 1'b0;
      #1;
      reset_models();
      for (int i = 1; i < 8; i++) begin
         a_rs1 = reg_idx_t'(i);
         b_rs2 = 4'(i + 8);
         #1;
         check("rst_mid_a_rd1", 64'(a_rd1), 64'd0);
         check("rst_mid_a_busy", 64'(a_rs1_busy), 64'd0);
         check("rst_mid_b_rd2", b_rd2, 64'd0);
         check("rst_mid_b_busy", 64'(b_rs2_busy), 64'd0);
      end
      check("rst_mid_a_cnt", 64'(a_busy_cnt), 64'd0);
      check("rst_mid_b_cnt", 64'(b_busy_cnt), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      random_cycles(200);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor of the pipeline's integer register file.
- Generalised XLEN and register count; two combinational read ports; one synchronous write port.
- Adds optional write-to-read bypass.
- Adds an integrated busy scoreboard: per-register pending-write flags for the hazard unit in ID, set on issue and cleared on writeback.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; must be a power of two, at least 2.
- AW, $clog2(NREGS), register index width; derived, not overridden.
- BYPASS, 1, 1 = same-cycle writeback data/busy-clear is visible on read ports; 0 = visible only after the clock edge.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- rs1  in  AW  read port 1 index.
- rs2  in  AW  read port 2 index.
- rd1  out  XLEN  read port 1 data.
- rd2  out  XLEN  read port 2 data.
- rs1_busy  out  1  register rs1 has an outstanding write.
- rs2_busy  out  1  register rs2 has an outstanding write.
- regwrite  in  1  writeback enable.
- rd  in  AW  writeback index.
- wd  in  XLEN  writeback data.
- alloc_en  in  1  issue marks a destination pending.
- alloc_rd  in  AW  destination index being issued.
- busy_cnt  out  AW+1  number of registers currently busy.

Behaviour:
- Reset: rst_n low asynchronously clears all registers, all busy bits and busy_cnt to 0. rd1/rd2 therefore read 0, and rs1_busy/rs2_busy read 0, while reset is held. Reset mid-operation discards pending allocations.
- Register 0 is hardwired zero:
  - writes to index 0 are ignored;
  - alloc_rd = 0 is ignored;
  - reads of index 0 return 0 and busy 0 regardless of bypass.
- Write: on posedge clk, if regwrite and rd != 0, regs[rd] <= wd. Latency 1 cycle without bypass.
- Read: rd1/rd2 are combinational from the array.
- Bypass (BYPASS=1): if regwrite and rd != 0 and rd == rsN, rdN = wd in the same cycle (write-first). Both ports bypass independently; rs1 == rs2 == rd forwards wd on both.
- Scoreboard, per index i != 0, next busy[i]:
  - alloc_en && alloc_rd==i: 1 (set wins over clear; new producer overrides the retiring one).
  - otherwise, regwrite && rd==i: 0.
  - otherwise: hold.
- Writeback to a non-busy register is legal: data is written, busy stays 0.
- Re-alloc of an already-busy register keeps busy at 1; there is no per-register count (single outstanding producer tracking).
- rsN_busy:
  - BYPASS=1: busy[rsN] & ~(regwrite && rd==rsN), i.e. a same-cycle writeback clears it combinationally.
  - BYPASS=0: busy[rsN] registered value.
  - Same-cycle alloc does not raise rsN_busy until the next cycle.
- busy_cnt: registered popcount of busy bits, updated every edge: +1 on a set of a clear bit, -1 on a clear of a set bit, net 0 when both happen on different indices with those conditions. Range 0..NREGS-1, no wrap possible.
- No X propagation: indices are always in range by construction, since NREGS = 2^AW.

Decomposition:
- Package rf_pkg holds:
  - XLEN_DEFAULT = 32 and NREGS_DEFAULT = 32;
  - the ZERO_REG = 0 constant;
  - typedef reg_idx_t for the AW-bit index;
  - typedef xword_t for the XLEN-bit data word.
- Sub-module rf_scoreboard (parameters NREGS, BYPASS) owns the busy vector, busy_cnt and the rsN_busy logic.
- The top level owns the data array and the bypass muxes.

Test Plan:
- Reset with rst_n=0 mid-run after writes and allocs -> all reads 0, rs1_busy=rs2_busy=0, busy_cnt=0 immediately, without waiting for a clock edge.
- Write x6=A4562D47, next cycle rs1=6 -> rd1=A4562D47. Same-cycle read with BYPASS=1 -> A4562D47; with BYPASS=0 -> old value 0.
- regwrite=1, rd=0, wd=DEADBEEF, alloc_rd=0 -> rs1=0 reads 0, busy_cnt stays 0.
- alloc x7, then rs2=7 -> rs2_busy=1 and busy_cnt=1. Writeback x7=CAFEBABE with BYPASS=1 -> same cycle rs2_busy=0 and rd2=CAFEBABE; next cycle busy_cnt=0.
- Simultaneous alloc x5 and writeback x5=12345678 -> x5 reads 12345678, busy[5] stays 1, busy_cnt unchanged.
- NREGS=16, XLEN=64: write x15=FFFF_0000_1234_5678, alloc x1 and x15, writeback x1 -> rd reads correct, busy_cnt sequence 0, 2, 1.
